// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage.
// Radix-2 restoring divide, one quotient bit per cycle, with pipeline stall
// request, flush (annul) cancellation and HI/LO result holding registers.
module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              annul,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              ready,
    output logic              busy,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DZERO = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    // dvd_q starts as the dividend magnitude and fills up with quotient bits
    // from the right as dividend bits are shifted out of the left.
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] prem_q;     // partial remainder
    logic [DATA_W-1:0] dsr_q;      // divisor magnitude
    logic              qneg_q;     // negate quotient at the end
    logic              rneg_q;     // negate remainder at the end
    logic [DATA_W-1:0] quo_q;      // held LO result
    logic [DATA_W-1:0] rem_q;      // held HI result

    // Operand magnitudes at acceptance (only meaningful in signed mode)
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              accept;

    // One restoring-divide step
    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   trial;
    logic              q_bit;
    logic [DATA_W-1:0] prem_d;

    // Sign-corrected results presented in DONE
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;
    logic              done_ok;

    // Operand conditioning and acceptance decode
    always_comb begin
        a_neg  = signed_div & dividend[DATA_W-1];
        b_neg  = signed_div & divisor[DATA_W-1];
        a_mag  = a_neg ? (-dividend) : dividend;
        b_mag  = b_neg ? (-divisor) : divisor;
        accept = (state_q == S_IDLE) & start & ~annul;
    end

    // Shift the next dividend bit in and trial-subtract in DATA_W+1 bits
    always_comb begin
        partial = {prem_q, dvd_q[DATA_W-1]};
        trial   = partial - {1'b0, dsr_q};
        q_bit   = ~trial[DATA_W];
        prem_d  = q_bit ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
    end

    // Final sign fix; divide-by-zero clears both flags so raw values pass
    always_comb begin
        q_fix = qneg_q ? (-dvd_q) : dvd_q;
        r_fix = rneg_q ? (-prem_q) : prem_q;
    end

    // Results are shown live in an un-annulled DONE cycle, otherwise the
    // held copy, so an annul in DONE leaves the visible results untouched.
    always_comb begin
        done_ok   = (state_q == S_DONE) & ~annul;
        ready     = done_ok;
        busy      = (state_q != S_IDLE);
        quotient  = done_ok ? q_fix : quo_q;
        remainder = done_ok ? r_fix : rem_q;
        stall_req = ~annul & (((state_q == S_IDLE) & start) |
                              (state_q == S_DZERO) | (state_q == S_RUN));
    end

    // Sequencer state, iteration datapath and result holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            prem_q  <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        dsr_q <= b_mag;
                        if (divisor == '0) begin
                            // Divide by zero: fixed result, no sign handling
                            state_q <= S_DZERO;
                            dvd_q   <= '1;
                            prem_q  <= dividend;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            dvd_q   <= a_mag;
                            prem_q  <= '0;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                        end
                    end
                end
                S_DZERO: begin
                    state_q <= annul ? S_IDLE : S_DONE;
                end
                S_RUN: begin
                    if (annul) begin
                        state_q <= S_IDLE;
                    end else begin
                        prem_q <= prem_d;
                        dvd_q  <= {dvd_q[DATA_W-2:0], q_bit};
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!annul) begin
                        quo_q <= q_fix;
                        rem_q <= r_fix;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases, annul/reset corner
// cases and randomized divides checked against an arithmetic reference.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        ready;
    logic        busy;
    logic        stall_req;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .busy       (busy),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    // Reference: integer division truncating toward zero, with the
    // divide-by-zero and signed-overflow results defined by the block.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input bit s, output logic [31:0] q,
                                  output logic [31:0] r, output int lat);
        int sa;
        int sb;
        sa = a;
        sb = b;
        lat = (b == 32'd0) ? 2 : 33;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Issue one divide from IDLE and follow it to ready. Returns observed
    // results, cycles from acceptance to ready, and stall_req violations.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int stall_bad);
        @(negedge clk);
        dividend = a; divisor = b; signed_div = s; start = 1'b1; annul = 1'b0;
        #1;
        lat = 0;
        stall_bad = 0;
        while (ready !== 1'b1 && lat < 100) begin
            if (stall_req !== 1'b1) stall_bad++;
            @(negedge clk);
            if (lat == 0) begin
                dividend = $urandom; divisor = $urandom; signed_div = 1'($urandom);
            end
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        if (stall_req !== 1'b0) stall_bad++;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({quotient, remainder} !== 64'd0) begin
            fails++; $display("FAIL reset_results got=%h/%h exp=0/0", quotient, remainder);
        end
        tests_run++;
        if ({ready, busy, stall_req} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got ready/busy/stall=%b exp=000", {ready, busy, stall_req});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL post_reset_busy got=%b exp=0", busy);
        end
    endtask

    // Shared body for the directed cases: compare against the model
    task automatic test_directed(input string name, input logic [31:0] a,
                                 input logic [31:0] b, input bit s);
        logic [31:0] q, r, eq, er;
        int lat, elat, sb;
        model(a, b, s, eq, er, elat);
        run_div(a, b, s, q, r, lat, sb);
        tests_run++;
        if (q !== eq || r !== er) begin
            fails++; $display("FAIL %s result got q=%h r=%h exp q=%h r=%h", name, q, r, eq, er);
        end
        tests_run++;
        if (lat !== elat) begin
            fails++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat);
        end
        tests_run++;
        if (sb !== 0) begin
            fails++; $display("FAIL %s stall_req got %0d bad cycles exp=0", name, sb);
        end
        last_q = eq; last_r = er;
        $display("[TB] %s %h/%h s=%0d -> q=%h r=%h lat=%0d", name, a, b, s, q, r, lat);
    endtask

    task automatic test_divu();
        test_directed("divu_100_7", 32'd100, 32'd7, 1'b0);
        tests_run++;
        if (last_q !== 32'd14 || last_r !== 32'd2) begin
            fails++; $display("FAIL divu_100_7_const got q=%h r=%h exp q=e r=2", last_q, last_r);
        end
        test_directed("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    endtask

    task automatic test_signed();
        test_directed("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        tests_run++;
        if (last_q !== 32'hFFFF_FFFD || last_r !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL div_m7_2_const got q=%h r=%h exp q=fffffffd r=ffffffff", last_q, last_r);
        end
        test_directed("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        test_directed("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if (last_q !== 32'h8000_0000 || last_r !== 32'd0) begin
            fails++; $display("FAIL div_ovf_const got q=%h r=%h exp q=80000000 r=0", last_q, last_r);
        end
    endtask

    task automatic test_div_zero();
        test_directed("divu_zero", 32'h1234_5678, 32'd0, 1'b0);
        test_directed("div_neg_zero", 32'hFFFF_FFFB, 32'd0, 1'b1);
    endtask

    // Flush in the middle of RUN: no ready, held results untouched
    task automatic test_annul_run();
        int seen_ready = 0;
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (ready === 1'b1) seen_ready++;
        end
        annul = 1'b1;
        #1;
        tests_run++;
        if (stall_req !== 1'b0 || ready !== 1'b0) begin
            fails++; $display("FAIL annul_run_same_cycle got stall=%b ready=%b exp 0 0", stall_req, ready);
        end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL annul_run_idle got busy=%b exp=0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ready === 1'b1) seen_ready++;
        end
        tests_run++;
        if (seen_ready !== 0) begin
            fails++; $display("FAIL annul_run_ready got %0d pulses exp=0", seen_ready);
        end
        tests_run++;
        if (quotient !== last_q || remainder !== last_r) begin
            fails++; $display("FAIL annul_run_hold got q=%h r=%h exp q=%h r=%h", quotient, remainder, last_q, last_r);
        end
        $display("[TB] annul_run q=%h r=%h", quotient, remainder);
    endtask

    // Flush exactly in the DONE cycle
    task automatic test_annul_done();
        @(negedge clk);
        dividend = 32'd9; divisor = 32'd3; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == 33) annul = 1'b1;
            #1;
        end
        tests_run++;
        if (ready !== 1'b0 || stall_req !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL annul_done_flags got ready/stall/busy=%b exp=001", {ready, stall_req, busy});
        end
        tests_run++;
        if (quotient !== last_q || remainder !== last_r) begin
            fails++; $display("FAIL annul_done_live got q=%h r=%h exp q=%h r=%h", quotient, remainder, last_q, last_r);
        end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || quotient !== last_q || remainder !== last_r) begin
            fails++; $display("FAIL annul_done_hold got busy=%b q=%h r=%h exp busy=0 q=%h r=%h", busy, quotient, remainder, last_q, last_r);
        end
        $display("[TB] annul_done q=%h r=%h", quotient, remainder);
    endtask

    // start together with annul in IDLE must not be accepted
    task automatic test_annul_idle();
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
        #1;
        tests_run++;
        if (stall_req !== 1'b0) begin
            fails++; $display("FAIL annul_idle_stall got=%b exp=0", stall_req);
        end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL annul_idle_busy got=%b exp=0", busy);
        end
        $display("[TB] annul_idle busy=%b", busy);
    endtask

    // start held through DONE is ignored; the next op starts from IDLE
    task automatic test_back_to_back();
        int lat = 0;
        @(negedge clk);
        dividend = 32'd20; divisor = 32'd3; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        #1;
        while (ready !== 1'b1 && lat < 100) begin
            @(negedge clk); #1; lat++;
        end
        tests_run++;
        if (quotient !== 32'd6 || remainder !== 32'd2 || lat !== 33) begin
            fails++; $display("FAIL b2b_first got q=%h r=%h lat=%0d exp q=6 r=2 lat=33", quotient, remainder, lat);
        end
        dividend = 32'd45; divisor = 32'd4;
        @(negedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || stall_req !== 1'b1) begin
            fails++; $display("FAIL b2b_idle got busy=%b stall=%b exp busy=0 stall=1", busy, stall_req);
        end
        lat = 0;
        while (ready !== 1'b1 && lat < 100) begin
            @(negedge clk); #1; lat++;
        end
        tests_run++;
        if (quotient !== 32'd11 || remainder !== 32'd1 || lat !== 33) begin
            fails++; $display("FAIL b2b_second got q=%h r=%h lat=%0d exp q=b r=1 lat=33", quotient, remainder, lat);
        end
        start = 1'b0;
        last_q = 32'd11; last_r = 32'd1;
        $display("[TB] back_to_back q=%h r=%h lat=%0d", quotient, remainder, lat);
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        int lat, elat, sb;
        bit s;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 17);
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            s = 1'($urandom);
            model(a, b, s, eq, er, elat);
            run_div(a, b, s, q, r, lat, sb);
            tests_run++;
            if (q !== eq || r !== er || lat !== elat || sb !== 0) begin
                fails++;
                $display("FAIL rand%0d %h/%h s=%0d got q=%h r=%h lat=%0d stallbad=%0d exp q=%h r=%h lat=%0d",
                         n, a, b, s, q, r, lat, sb, eq, er, elat);
            end else begin
                $display("[TB] rand%0d %h/%h s=%0d -> q=%h r=%h lat=%0d", n, a, b, s, q, r, lat);
            end
            last_q = eq; last_r = er;
        end
    endtask

    // Reset asserted between clock edges during RUN
    task automatic test_async_reset();
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        tests_run++;
        if ({quotient, remainder} !== 64'd0 || {ready, busy, stall_req} !== 3'b000) begin
            fails++; $display("FAIL async_reset got q=%h r=%h ready/busy/stall=%b exp all 0",
                              quotient, remainder, {ready, busy, stall_req});
        end
        @(negedge clk);
        #3;
        rst = 1'b0;
        test_directed("divu_9_3_after_rst", 32'd9, 32'd3, 1'b0);
        tests_run++;
        if (last_q !== 32'd3 || last_r !== 32'd0) begin
            fails++; $display("FAIL after_rst_const got q=%h r=%h exp q=3 r=0", last_q, last_r);
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul_run();
        test_annul_done();
        test_annul_idle();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
